// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART tx path between NUM_REQ requesters.
// A grant lasts one message, or ends early after MAX_BURST bytes or TIMEOUT idle cycles.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 64,
  parameter int TIMEOUT   = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     in_valid,
  input  logic [8*NUM_REQ-1:0]   in_data,
  input  logic [NUM_REQ-1:0]     in_last,
  output logic [NUM_REQ-1:0]     in_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic                   forced
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [2:0]  ptr, grant, pick;
  logic        pick_vld;
  logic [7:0]  byte_cnt;
  logic [15:0] idle_cnt;
  logic        lane_valid, lane_last;
  logic [7:0]  lane_data;
  logic        xfer, release_last, release_forced;

  // Winner is the valid lane with the smallest distance past ptr, so ptr itself ranks last.
  always_comb begin
    int d;
    int best;
    pick     = '0;
    pick_vld = 1'b0;
    best     = NUM_REQ;
    d        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = i + NUM_REQ - 1 - int'(ptr);
      if (d >= NUM_REQ) d = d - NUM_REQ;
      if (in_valid[i] && (d < best)) begin
        best     = d;
        pick     = 3'(i);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    lane_valid = 1'b0;
    lane_last  = 1'b0;
    lane_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == 3'(i)) begin
        lane_valid = in_valid[i];
        lane_last  = in_last[i];
        lane_data  = in_data[8*i +: 8];
      end
    end
  end

  assign xfer           = (state == LOCKED) && lane_valid && tx_ready;
  assign release_last   = xfer && lane_last;
  // in_last wins over a burst limit hit on the same byte, so no forced pulse then.
  assign release_forced = (xfer && !lane_last && (byte_cnt + 8'd1 == 8'(MAX_BURST))) ||
                          ((state == LOCKED) && !lane_valid && (idle_cnt == 16'(TIMEOUT - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = LOCKED;
      LOCKED:  if (release_last || release_forced) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    in_ready = '0;
    if (state == LOCKED) begin
      tx_valid = lane_valid;
      tx_data  = lane_data;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant == 3'(i)) in_ready[i] = tx_ready;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= 3'(NUM_REQ - 1);
      grant    <= 3'd0;
      byte_cnt <= 8'd0;
      idle_cnt <= 16'd0;
      grant_id <= 3'd0;
      busy     <= 1'b0;
      forced   <= 1'b0;
    end else begin
      forced <= release_forced;
      busy   <= (state_nxt == LOCKED);
      if (state == IDLE) begin
        if (pick_vld) begin
          grant    <= pick;
          ptr      <= pick;
          grant_id <= pick;
          byte_cnt <= 8'd0;
          idle_cnt <= 16'd0;
        end
      end else begin
        if (release_last || release_forced) grant_id <= 3'd0;
        if (xfer) begin
          byte_cnt <= byte_cnt + 8'd1;
          idle_cnt <= 16'd0;
        end else if (!lane_valid) begin
          idle_cnt <= idle_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, hand-written corner sequences and a random run
// against a message-level reference model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   in_valid = '0;
  logic [8*N-1:0] in_data = '0;
  logic [N-1:0]   in_last = '0;
  logic [N-1:0]   in_ready;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready = 1'b0;
  logic [2:0]     grant_id;
  logic           busy;
  logic           forced;

  int total = 0;
  int bad = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant_id(grant_id), .busy(busy), .forced(forced)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           rst;
    logic [N-1:0]   iv;
    logic [8*N-1:0] data;
    logic [N-1:0]   il;
    logic           tr;
    logic           busy;
    logic [2:0]     gid;
    logic           tv;
    logic [7:0]     td;
    logic [N-1:0]   ir;
    logic           forced;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [N-1:0] iv, input logic [8*N-1:0] d,
                     input logic [N-1:0] il, input logic tr, input logic b, input logic [2:0] g,
                     input logic tv, input logic [7:0] td, input logic [N-1:0] ir, input logic f);
    vec_t v;
    v = '{r, iv, d, il, tr, b, g, tv, td, ir, f};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = '0; in_last = '0; in_data = '0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [17:0] pack_out();
    return {busy, grant_id, forced, tx_valid, tx_data, in_ready};
  endfunction

  // reference model state
  int owner, last_rel, sent, quiet;
  logic fexp;
  logic [7:0] msg3[3];
  logic [7:0] msg5[5];
  logic [7:0] got[$];
  int k, cyc;
  bit forced_seen, done;
  logic [17:0] exp_o;

  initial begin
    // hello message from req0
    add(1, 4'b0001, 32'h48, 4'b0000, 1, 0, 0, 0, 8'h00, 4'b0000, 0);
    add(0, 4'b0001, 32'h48, 4'b0000, 1, 0, 0, 0, 8'h00, 4'b0000, 0);
    add(0, 4'b0001, 32'h48, 4'b0000, 1, 1, 0, 1, 8'h48, 4'b0001, 0);
    add(0, 4'b0001, 32'h49, 4'b0000, 1, 1, 0, 1, 8'h49, 4'b0001, 0);
    add(0, 4'b0001, 32'h0A, 4'b0001, 1, 1, 0, 1, 8'h0A, 4'b0001, 0);
    add(0, 4'b0000, 32'h00, 4'b0000, 1, 0, 0, 0, 8'h00, 4'b0000, 0);
    // req1 and req2 contend, two rounds
    add(1, 4'b0110, 32'h00B1A100, 4'b0000, 1, 0, 0, 0, 8'h00, 4'b0000, 0);
    add(0, 4'b0110, 32'h00B1A100, 4'b0000, 1, 0, 0, 0, 8'h00, 4'b0000, 0);
    add(0, 4'b0110, 32'h00B1A100, 4'b0000, 1, 1, 1, 1, 8'hA1, 4'b0010, 0);
    add(0, 4'b0110, 32'h00B1A200, 4'b0010, 1, 1, 1, 1, 8'hA2, 4'b0010, 0);
    add(0, 4'b0110, 32'h00B1C100, 4'b0000, 1, 0, 0, 0, 8'h00, 4'b0000, 0);
    add(0, 4'b0110, 32'h00B1C100, 4'b0000, 1, 1, 2, 1, 8'hB1, 4'b0100, 0);
    add(0, 4'b0110, 32'h00B2C100, 4'b0100, 1, 1, 2, 1, 8'hB2, 4'b0100, 0);
    add(0, 4'b0110, 32'h00D1C100, 4'b0000, 1, 0, 0, 0, 8'h00, 4'b0000, 0);
    add(0, 4'b0110, 32'h00D1C100, 4'b0010, 1, 1, 1, 1, 8'hC1, 4'b0010, 0);
    add(0, 4'b0000, 32'h00000000, 4'b0000, 1, 0, 0, 0, 8'h00, 4'b0000, 0);
    // burst limit: req0 streams without last, req3 waiting
    add(1, 4'b1001, 32'hF0000000, 4'b0000, 1, 0, 0, 0, 8'h00, 4'b0000, 0);
    add(0, 4'b1001, 32'hF0000000, 4'b0000, 1, 0, 0, 0, 8'h00, 4'b0000, 0);
    add(0, 4'b1001, 32'hF0000000, 4'b0000, 1, 1, 0, 1, 8'h00, 4'b0001, 0);
    add(0, 4'b1001, 32'hF0000001, 4'b0000, 1, 1, 0, 1, 8'h01, 4'b0001, 0);
    add(0, 4'b1001, 32'hF0000002, 4'b0000, 1, 1, 0, 1, 8'h02, 4'b0001, 0);
    add(0, 4'b1001, 32'hF0000003, 4'b0000, 1, 1, 0, 1, 8'h03, 4'b0001, 0);
    add(0, 4'b1001, 32'hF0000004, 4'b0000, 1, 0, 0, 0, 8'h00, 4'b0000, 1);
    add(0, 4'b1001, 32'hF0000004, 4'b1000, 1, 1, 3, 1, 8'hF0, 4'b1000, 0);
    add(0, 4'b1001, 32'hF0000004, 4'b0000, 1, 0, 0, 0, 8'h00, 4'b0000, 0);
    add(0, 4'b1001, 32'hF0000004, 4'b0000, 1, 1, 0, 1, 8'h04, 4'b0001, 0);
    // timeout: req2 sends one byte then goes quiet, req0 waiting
    add(1, 4'b0100, 32'h00550077, 4'b0000, 1, 0, 0, 0, 8'h00, 4'b0000, 0);
    add(0, 4'b0100, 32'h00550077, 4'b0000, 1, 0, 0, 0, 8'h00, 4'b0000, 0);
    add(0, 4'b0101, 32'h00550077, 4'b0000, 1, 1, 2, 1, 8'h55, 4'b0100, 0);
    for (int i = 0; i < TO; i++)
      add(0, 4'b0001, 32'h00550077, 4'b0000, 1, 1, 2, 0, 8'h55, 4'b0100, 0);
    add(0, 4'b0001, 32'h00550077, 4'b0000, 1, 0, 0, 0, 8'h00, 4'b0000, 1);
    add(0, 4'b0001, 32'h00550077, 4'b0000, 1, 1, 0, 1, 8'h77, 4'b0001, 0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst; in_valid = vecs[i].iv; in_data = vecs[i].data;
      in_last = vecs[i].il; tx_ready = vecs[i].tr;
      @(negedge clk);
      check($sformatf("vec%0d", i), {46'd0, pack_out()},
            {46'd0, vecs[i].busy, vecs[i].gid, vecs[i].forced, vecs[i].tv, vecs[i].td, vecs[i].ir});
    end

    // paced tx_ready with an initial long stall that must not count as idle
    msg3 = '{8'h11, 8'h22, 8'h33};
    do_reset();
    in_valid = 4'b0001; in_data = 32'h11;
    repeat (14) @(posedge clk);
    @(negedge clk);
    check("stall_busy", {busy, grant_id}, {1'b1, 3'd0});
    k = 0; forced_seen = 0; got.delete();
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      tx_ready = (c % 3 == 0);
      in_valid[0] = (k < 3);
      in_data[7:0] = (k < 3) ? msg3[k] : 8'h00;
      in_last[0] = (k == 2);
      @(negedge clk);
      check("pace_ready", {63'd0, in_ready[0]}, {63'd0, tx_ready & (k < 3)});
      if (forced) forced_seen = 1;
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        k++;
      end
    end
    check("pace_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("pace_byte%0d", i), (i < got.size()) ? {56'd0, got[i]} : 64'hDEAD, {56'd0, msg3[i]});
    check("pace_forced", {63'd0, forced_seen}, 64'd0);

    // asynchronous reset mid-message
    msg5 = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
    do_reset();
    in_valid = 4'b0010; tx_ready = 1'b1; k = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      in_data[15:8] = msg5[k];
      in_last[1] = (k == 4);
      @(negedge clk);
      if (tx_valid && tx_ready) k++;
      if (k == 2) done = 1;
      @(posedge clk);
      #1;
    end
    check("midmsg_reached", {63'd0, done}, 64'd1);
    in_data[15:8] = msg5[k];
    check("midmsg_locked", {busy, grant_id}, {1'b1, 3'd1});
    #2 rst = 1'b1;
    in_valid = 4'b0110;
    #1;
    check("async_rst_out", {46'd0, pack_out()}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {46'd0, pack_out()}, 64'd0);
    @(negedge clk);
    check("post_rst_pick", {busy, grant_id}, {1'b1, 3'd1});

    // random traffic against the reference model
    do_reset();
    owner = -1; last_rel = N - 1; sent = 0; quiet = 0; fexp = 0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(5) == 0) in_valid[i] = ~in_valid[i];
        in_data[8*i +: 8] = 8'($urandom);
        in_last[i] = ($urandom_range(3) == 0);
      end
      tx_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      exp_o = '0;
      exp_o[16] = fexp;
      if (owner >= 0) begin
        exp_o[17]    = 1'b1;
        exp_o[16:14] = 3'(owner);
        exp_o[16]    = 1'b0;
        exp_o[15:13] = 3'(owner);
      end
      exp_o = {owner >= 0, (owner >= 0) ? 3'(owner) : 3'd0, fexp,
               (owner >= 0) ? in_valid[owner] : 1'b0,
               (owner >= 0) ? in_data[8*owner +: 8] : 8'h00,
               (owner >= 0) ? (4'(tx_ready) << owner) : 4'b0000};
      check("random", {46'd0, pack_out()}, {46'd0, exp_o});
      // advance model to the next edge
      fexp = 0;
      if (owner < 0) begin
        for (int j = N; j >= 1; j--)
          if (in_valid[(last_rel + j) % N]) owner = (last_rel + j) % N;
        if (owner >= 0) begin
          last_rel = owner; sent = 0; quiet = 0;
        end
      end else if (in_valid[owner] && tx_ready) begin
        sent++; quiet = 0;
        if (in_last[owner]) owner = -1;
        else if (sent == MB) begin owner = -1; fexp = 1; end
      end else if (!in_valid[owner]) begin
        if (quiet == TO - 1) begin owner = -1; fexp = 1; end
        else quiet++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
